// File: rtl/cva6_fifo_pkg.sv
// Shared types for the cva6_fifo_v4 FIFO.
// fifo_status_t groups the four status flags derived from the entry count.
package cva6_fifo_pkg;

    // Largest supported number of entries.
    localparam int unsigned MAX_DEPTH = 65536;

    // Status flags derived from the registered entry count.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/cva6_fifo_mem.sv
// Storage array for cva6_fifo_v4.
// One synchronous write port and one asynchronous read port. The array is not reset.
// Ports:
//   clk_i   - clock, rising edge
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data, combinational from raddr_i
module cva6_fifo_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter type         dtype  = logic [31:0]
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  dtype              wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output dtype              rdata_o
);

    dtype mem_q [DEPTH];

    // Write-enabled entry registers.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cva6_fifo_v4.sv
// Synchronous FIFO with optional fall-through, almost-full/empty thresholds,
// usage count and sticky overflow/underflow flags.
// Ports:
//   clk_i          - clock, rising edge
//   rst_ni         - synchronous active-low reset
//   flush_i        - empties the FIFO next cycle, ignores same-cycle push/pop
//   err_clr_i      - clears the sticky error flags
//   data_i/push_i  - push data and request
//   pop_i          - pop request
//   data_o         - head entry (data_i when falling through an empty FIFO)
//   full_o, empty_o, almost_full_o, almost_empty_o - status flags
//   usage_o        - entry count 0..DEPTH
//   overflow_o, underflow_o - sticky error flags
module cva6_fifo_v4
    import cva6_fifo_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned AF_THRESH    = DEPTH - 1,
    parameter int unsigned AE_THRESH    = 1,
    // Derived; leave at its default.
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             err_clr_i,
    input  dtype             data_i,
    input  logic             push_i,
    input  logic             pop_i,
    output dtype             data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CNT_W-1:0] usage_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > MAX_DEPTH || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : gen_bad_params
        $error("cva6_fifo_v4: illegal DEPTH/AE_THRESH/AF_THRESH combination");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, unf_q;

    fifo_status_t status;
    dtype         mem_rdata;
    logic         ft_empty;
    logic         bypass;
    logic         push_ok, pop_ok;
    logic         ovf_evt, unf_evt;
    logic         wr_en;

    // Wrap by compare so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Empty FIFO in fall-through mode passes data_i straight to data_o.
    assign ft_empty = FALL_THROUGH && (cnt_q == '0);
    // Push and pop both served by the bypass: storage untouched.
    assign bypass   = ft_empty && push_i && pop_i;

    // Status flags from the registered count.
    always_comb begin
        status              = '0;
        status.full         = (cnt_q == CNT_W'(DEPTH));
        status.empty        = ft_empty ? !push_i : (cnt_q == '0);
        status.almost_full  = (32'(cnt_q) >= AF_THRESH);
        status.almost_empty = (32'(cnt_q) <= AE_THRESH);
    end

    assign push_ok = push_i && !status.full;
    assign pop_ok  = pop_i && !status.empty;
    assign ovf_evt = !flush_i && push_i && status.full;
    assign unf_evt = !flush_i && pop_i && status.empty;
    assign wr_en   = rst_ni && !flush_i && push_ok && !bypass;

    // Next pointers and count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else if (!bypass) begin
            if (push_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers; a new error outranks a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= (ovf_q && !err_clr_i) || ovf_evt;
            unf_q    <= (unf_q && !err_clr_i) || unf_evt;
        end
    end

    cva6_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W),
        .dtype  (dtype)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign data_o         = ft_empty ? data_i : mem_rdata;
    assign full_o         = status.full;
    assign empty_o        = status.empty;
    assign almost_full_o  = status.almost_full;
    assign almost_empty_o = status.almost_empty;
    assign usage_o        = cnt_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule
